regfile_scb: RTL and testbench

Parametrised register file for the RV32I datapath with a built-in scoreboard, optional write-to-read bypass and a sequenced clear. It keeps the existing two-read/one-write, zero-register semantics and adds configurable width and depth. A per-register pending bit tracks issued-but-not-written destinations. A `CLEAR` state machine zeroes the file one entry per cycle on request. It sits between decode (read addresses, destination issue) and writeback.

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_scoreboard.sv | 27 ++
 rtl/regfile_scb.sv | 73 +++++++
 tb/tb_regfile_scb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state encoding and default geometry for the register file
package regfile_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits (set wins over clear on the same entry), ports clk_regs/rst_n, set/clr strobes+addresses, two lookup addresses -> busy bits
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_regs,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              busy_a,
  output logic              busy_b
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] pend;
  always_ff @(posedge clk_regs or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      if (set_en) pend[set_addr] <= 1'b1;
    end
  end
  assign busy_a = pend[addr_a];
  assign busy_b = pend[addr_b];
endmodule

// File: rtl/regfile_scb.sv
// regfile_scb: 2R/1W register file with pending scoreboard, write bypass and sequenced clear; ports read A/B addr->data/busy, issue, writeback, Clr_Req->Clr_Busy
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk_regs,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] R_ADDR_A,
  input  logic [ADDR_W-1:0] R_ADDR_B,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic              R_Busy_A,
  output logic              R_Busy_B,
  input  logic              Iss_Valid,
  input  logic [ADDR_W-1:0] Iss_ADDR,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] W_ADDR,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Clr_Req,
  output logic              Clr_Busy
);
  localparam int DEPTH = 2**ADDR_W;
  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic idle, wr_ok, iss_ok, zero_a, zero_b, byp_a, byp_b, pend_a, pend_b;
  assign idle   = state == ST_IDLE;
  assign wr_ok  = idle && Reg_Write && !(ZERO_REG && W_ADDR == '0);
  assign iss_ok = idle && Iss_Valid && !(ZERO_REG && Iss_ADDR == '0);
  always_comb begin
    state_d = idle ? (Clr_Req ? ST_CLEAR : ST_IDLE) : (&cnt ? ST_IDLE : ST_CLEAR);
    cnt_d   = idle ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk_regs or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  always_ff @(posedge clk_regs or negedge rst_n) begin
    if (!rst_n) mem <= '{default: '0};
    else if (wr_ok) mem[W_ADDR] <= W_Data;
    else if (!idle) mem[cnt] <= '0;
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scb (
    .clk_regs (clk_regs),
    .rst_n    (rst_n),
    .set_en   (iss_ok),
    .set_addr (Iss_ADDR),
    .clr_en   (wr_ok || !idle),
    .clr_addr (idle ? W_ADDR : cnt),
    .addr_a   (R_ADDR_A),
    .addr_b   (R_ADDR_B),
    .busy_a   (pend_a),
    .busy_b   (pend_b)
  );
  assign zero_a   = ZERO_REG && R_ADDR_A == '0;
  assign zero_b   = ZERO_REG && R_ADDR_B == '0;
  assign byp_a    = BYPASS && wr_ok && W_ADDR == R_ADDR_A;
  assign byp_b    = BYPASS && wr_ok && W_ADDR == R_ADDR_B;
  assign R_Data_A = zero_a ? '0 : byp_a ? W_Data : mem[R_ADDR_A];
  assign R_Data_B = zero_b ? '0 : byp_b ? W_Data : mem[R_ADDR_B];
  assign R_Busy_A = !zero_a && !byp_a && pend_a;
  assign R_Busy_B = !zero_b && !byp_b && pend_b;
  assign Clr_Busy = !idle;
endmodule

// File: tb/tb_regfile_scb.sv
// tb_regfile_scb: directed stimulus pushes expectations into a queue; a negedge monitor pops and compares against the DUT outputs
module tb_regfile_scb;
  logic        clk_regs = 1'b0;
  logic        rst_n;
  logic [4:0]  R_ADDR_A, R_ADDR_B, Iss_ADDR, W_ADDR;
  logic [31:0] R_Data_A, R_Data_B, W_Data;
  logic        R_Busy_A, R_Busy_B, Iss_Valid, Reg_Write, Clr_Req, Clr_Busy;
  logic        done = 1'b0;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] v;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk_regs = ~clk_regs;
  regfile_scb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk_regs (clk_regs),
    .rst_n    (rst_n),
    .R_ADDR_A (R_ADDR_A),
    .R_ADDR_B (R_ADDR_B),
    .R_Data_A (R_Data_A),
    .R_Data_B (R_Data_B),
    .R_Busy_A (R_Busy_A),
    .R_Busy_B (R_Busy_B),
    .Iss_Valid(Iss_Valid),
    .Iss_ADDR (Iss_ADDR),
    .Reg_Write(Reg_Write),
    .W_ADDR   (W_ADDR),
    .W_Data   (W_Data),
    .Clr_Req  (Clr_Req),
    .Clr_Busy (Clr_Busy)
  );
  task automatic step();
    @(posedge clk_regs);
    #1;
  endtask
  task automatic chk(input int kind, input logic [31:0] v, input string nm);
    exp_q.push_back('{nm, kind, v});
  endtask
  always @(negedge clk_regs) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      act = e.kind == 0 ? R_Data_A : e.kind == 1 ? {31'b0, R_Busy_A} :
            e.kind == 2 ? R_Data_B : e.kind == 3 ? {31'b0, R_Busy_B} : {31'b0, Clr_Busy};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
    if (done) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end
  initial begin
    #100000;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: stimulus did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end
  initial begin
    rst_n = 1'b0;
    {R_ADDR_A, R_ADDR_B, Iss_ADDR, W_ADDR} = '0;
    {Iss_Valid, Reg_Write, Clr_Req} = '0;
    W_Data = '0;
    step();
    checks++;
    if (Clr_Busy !== 1'b0 || R_Data_A !== '0 || R_Data_B !== '0 || R_Busy_A !== 1'b0 || R_Busy_B !== 1'b0) begin
      errors++;
      $display("FAIL rst_direct: clr_busy %b data_a %h data_b %h busy_a %b busy_b %b", Clr_Busy, R_Data_A, R_Data_B, R_Busy_A, R_Busy_B);
    end
    chk(4, 0, "rst_clr_busy");
    chk(0, 0, "rst_data_a");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      R_ADDR_A = 5'(i);
      R_ADDR_B = 5'(31 - i);
      chk(0, 0, $sformatf("rst_data_a_x%0d", i));
      chk(1, 0, $sformatf("rst_busy_a_x%0d", i));
      chk(2, 0, $sformatf("rst_data_b_x%0d", 31 - i));
      chk(3, 0, $sformatf("rst_busy_b_x%0d", 31 - i));
    end
    step();
    Reg_Write = 1'b1; W_ADDR = 5; W_Data = 32'hDEADBEEF; R_ADDR_A = 5;
    chk(0, 32'hDEADBEEF, "x5_bypass_data");
    chk(1, 0, "x5_bypass_busy");
    step();
    Reg_Write = 1'b0;
    chk(0, 32'hDEADBEEF, "x5_stored");
    step();
    Reg_Write = 1'b1; W_ADDR = 0; W_Data = 32'h1234; R_ADDR_A = 0;
    chk(0, 0, "x0_write_bypass");
    step();
    Reg_Write = 1'b0; Iss_Valid = 1'b1; Iss_ADDR = 0;
    chk(0, 0, "x0_after_write");
    chk(1, 0, "x0_busy_issue");
    step();
    Iss_Valid = 1'b0;
    chk(1, 0, "x0_busy_after_issue");
    step();
    Iss_Valid = 1'b1; Iss_ADDR = 7; R_ADDR_A = 7;
    chk(1, 0, "x7_busy_pre_issue");
    step();
    Iss_Valid = 1'b0; R_ADDR_B = 7;
    chk(1, 1, "x7_busy_a");
    chk(3, 1, "x7_busy_b");
    step();
    Reg_Write = 1'b1; W_ADDR = 7; W_Data = 32'h55;
    chk(0, 32'h55, "x7_wb_data");
    chk(1, 0, "x7_wb_busy_a");
    chk(3, 0, "x7_wb_busy_b");
    step();
    Iss_Valid = 1'b1; Iss_ADDR = 7; W_Data = 32'h77;
    chk(0, 32'h77, "x7_iss_wb_data");
    chk(1, 0, "x7_iss_wb_busy");
    step();
    Reg_Write = 1'b0; Iss_Valid = 1'b0; R_ADDR_B = 5;
    chk(0, 32'h77, "x7_after_data");
    chk(1, 1, "x7_after_busy");
    chk(2, 32'hDEADBEEF, "x5_port_b");
    chk(3, 0, "x5_busy_b");
    for (int i = 1; i < 32; i++) begin
      step();
      Reg_Write = 1'b1; W_ADDR = 5'(i); W_Data = i;
    end
    step();
    Reg_Write = 1'b0; Iss_Valid = 1'b1; Iss_ADDR = 12; R_ADDR_A = 31; R_ADDR_B = 1;
    chk(0, 31, "fill_x31");
    chk(2, 1, "fill_x1");
    step();
    Iss_Valid = 1'b0; R_ADDR_A = 12;
    chk(0, 12, "fill_x12");
    chk(1, 1, "x12_pending");
    step();
    Clr_Req = 1'b1; R_ADDR_A = 31; R_ADDR_B = 2;
    chk(4, 0, "clr_busy_pre");
    for (int k = 0; k < 32; k++) begin
      step();
      Clr_Req = k >= 5 && k <= 10;
      Reg_Write = 1'b1; W_ADDR = 31; W_Data = 32'hFFFF;
      Iss_Valid = 1'b1; Iss_ADDR = 20;
      chk(4, 1, $sformatf("clr_busy_k%0d", k));
      chk(0, 31, $sformatf("clr_no_bypass_k%0d", k));
      chk(1, 0, $sformatf("clr_busy_x31_k%0d", k));
      chk(2, k <= 2 ? 32'd2 : 32'd0, $sformatf("clr_progress_x2_k%0d", k));
    end
    step();
    Reg_Write = 1'b0; Iss_Valid = 1'b0; Clr_Req = 1'b0;
    chk(4, 0, "clr_done");
    for (int i = 0; i < 32; i++) begin
      step();
      R_ADDR_A = 5'(i);
      R_ADDR_B = 5'(i);
      chk(0, 0, $sformatf("post_clr_data_x%0d", i));
      chk(1, 0, $sformatf("post_clr_busy_x%0d", i));
    end
    step();
    Reg_Write = 1'b1; W_ADDR = 30; W_Data = 32'h30;
    step();
    W_ADDR = 4; W_Data = 32'h44;
    step();
    Reg_Write = 1'b0; Iss_Valid = 1'b1; Iss_ADDR = 4;
    step();
    Iss_Valid = 1'b0; Clr_Req = 1'b1; R_ADDR_A = 30; R_ADDR_B = 4;
    chk(0, 32'h30, "x30_before_clr");
    chk(3, 1, "x4_busy_before_clr");
    for (int k = 0; k < 10; k++) begin
      step();
      Clr_Req = 1'b0;
      chk(4, 1, $sformatf("clr2_busy_k%0d", k));
    end
    step();
    rst_n = 1'b0;
    chk(4, 0, "midclr_rst_busy");
    chk(0, 0, "midclr_rst_x30");
    chk(2, 0, "midclr_rst_x4");
    chk(3, 0, "midclr_rst_x4_busy");
    step();
    rst_n = 1'b1; Reg_Write = 1'b1; W_ADDR = 3; W_Data = 32'hABC; R_ADDR_A = 3;
    chk(0, 32'hABC, "x3_bypass_after_rst");
    step();
    Reg_Write = 1'b0;
    chk(0, 32'hABC, "x3_stored_after_rst");
    chk(1, 0, "x3_busy_after_rst");
    chk(4, 0, "clr_busy_after_rst");
    step();
    done = 1'b1;
  end
endmodule
